// File: rtl/systolic_feeder.sv
// systolic_feeder: input-side driver for an N x N systolic mesh.
// Takes one k-slice per beat (column k of A, row k of B), skews it into
// the row/column edge streams the mesh expects, zero-pads the tail during
// FLUSH, and drives the mesh clear/load controls for one product per start.
module systolic_feeder #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int KW     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] a_vec,
    input  logic [N*DATA_W-1:0] b_vec,
    output logic                pe_clr,
    output logic                pe_load,
    output logic [N*DATA_W-1:0] a_edge,
    output logic [N*DATA_W-1:0] b_edge,
    output logic                done
);

    // Zero-padding cycles needed to push the last slice through the
    // deepest skew row and across the mesh to PE(N-1,N-1).
    localparam int FLUSH_LEN = 2 * N - 2;
    localparam int FW        = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    // Unreachable when N = 1 (FLUSH is skipped), so its value there is moot.
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic          accept;
    logic          advance;
    logic          last_beat;
    logic          last_flush;
    logic          clr_stages;

    // A beat is taken only while FEED presents in_ready.
    assign accept     = in_ready && in_valid;
    // Every advance moves all skew stages one step and earns one mesh MAC.
    assign advance    = accept || (state == S_FLUSH);
    assign last_beat  = (beat_cnt == k_reg - KW'(1));
    assign last_flush = (flush_cnt == FLUSH_LAST);
    assign clr_stages = (state == S_CLEAR);

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create simulation order races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    // NOTE: every output gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        pe_clr    = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                pe_clr    = 1'b1;
                state_nxt = (k_reg == '0) ? S_DONE : S_FEED;
            end
            S_FEED: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_nxt = (FLUSH_LEN == 0) ? S_DRAIN : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (last_flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture K on an accepted start; later k_len changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg <= '0;
        end else if (state == S_IDLE && start) begin
            k_reg <= k_len;
        end
    end

    // Count accepted beats of the current product.
    always_ff @(posedge clk) begin
        if (rst || clr_stages) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
        end
    end

    // Count FLUSH cycles; held at zero outside FLUSH.
    always_ff @(posedge clk) begin
        if (rst || state != S_FLUSH) begin
            flush_cnt <= '0;
        end else begin
            flush_cnt <= flush_cnt + FW'(1);
        end
    end

    // Mesh load follows the advance one cycle later, aligned with the
    // registered edge data, so a stall freezes the mesh without re-MACing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_load <= 1'b0;
        end else begin
            pe_load <= advance;
        end
    end

    // Skew lines: row/column i has i+1 stages, stage 0 in the LSB chunk and
    // the edge output taken from the MSB chunk.
    for (genvar i = 0; i < N; i++) begin : g_skew
        localparam int W = (i + 1) * DATA_W;

        logic [W-1:0]      a_sr;
        logic [W-1:0]      b_sr;
        logic [DATA_W-1:0] a_in;
        logic [DATA_W-1:0] b_in;

        // Real data only while feeding; zeros pad the tail in FLUSH.
        assign a_in = (state == S_FEED) ? a_vec[i*DATA_W +: DATA_W] : '0;
        assign b_in = (state == S_FEED) ? b_vec[i*DATA_W +: DATA_W] : '0;

        // Shift row i of A on each advance; cleared on reset and in CLEAR.
        always_ff @(posedge clk) begin
            if (rst || clr_stages) begin
                a_sr <= '0;
            end else if (advance) begin
                a_sr <= (a_sr << DATA_W) | W'(a_in);
            end
        end

        // Shift column i of B on each advance; cleared on reset and in CLEAR.
        always_ff @(posedge clk) begin
            if (rst || clr_stages) begin
                b_sr <= '0;
            end else if (advance) begin
                b_sr <= (b_sr << DATA_W) | W'(b_in);
            end
        end

        assign a_edge[i*DATA_W +: DATA_W] = a_sr[W-1 -: DATA_W];
        assign b_edge[i*DATA_W +: DATA_W] = b_sr[W-1 -: DATA_W];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: a 2x2 instance drives a behavioural PE mesh
// whose results are scoreboarded on every done pulse; a 4x4 instance is
// used for the edge-skew timing.
module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int KW = 8;

    typedef logic [3:0][31:0] cmat_t;   // {C11, C10, C01, C00}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 2x2 instance
    logic            start2, in_valid2;
    logic [KW-1:0]   k_len2;
    logic [2*DW-1:0] a_vec2, b_vec2, a_edge2, b_edge2;
    logic            busy2, in_ready2, pe_clr2, pe_load2, done2;

    // 4x4 instance
    logic            start4, in_valid4;
    logic [KW-1:0]   k_len4;
    logic [4*DW-1:0] a_vec4, b_vec4, a_edge4, b_edge4;
    logic            busy4, in_ready4, pe_clr4, pe_load4, done4;

    systolic_feeder #(.DATA_W(DW), .N(2), .KW(KW)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .k_len(k_len2), .busy(busy2),
        .in_valid(in_valid2), .in_ready(in_ready2), .a_vec(a_vec2), .b_vec(b_vec2),
        .pe_clr(pe_clr2), .pe_load(pe_load2), .a_edge(a_edge2), .b_edge(b_edge2),
        .done(done2)
    );

    systolic_feeder #(.DATA_W(DW), .N(4), .KW(KW)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(k_len4), .busy(busy4),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_vec(a_vec4), .b_vec(b_vec4),
        .pe_clr(pe_clr4), .pe_load(pe_load4), .a_edge(a_edge4), .b_edge(b_edge4),
        .done(done4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural 2x2 output-stationary PE mesh fed by dut2.
    int          acc [2][2];
    logic [7:0]  pa  [2][2];
    logic [7:0]  pb  [2][2];

    always @(posedge clk) begin : mesh
        logic [7:0] ai, bi;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (pe_clr2 === 1'b1) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else if (pe_load2 === 1'b1) begin
                    if (j == 0) ai = a_edge2[i*DW +: DW];
                    else        ai = pa[i][j-1];
                    if (i == 0) bi = b_edge2[j*DW +: DW];
                    else        bi = pb[i-1][j];
                    acc[i][j] <= acc[i][j] + int'(ai) * int'(bi);
                    pa[i][j]  <= ai;
                    pb[i][j]  <= bi;
                end
            end
        end
    end

    // Scoreboard: expected C matrices queued at start, popped on done.
    cmat_t exp_q[$];

    always @(negedge clk) begin : monitor
        cmat_t e;
        if (done2 === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: done pulse with no product pending (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("c00", acc[0][0], e[0]);
                check("c01", acc[0][1], e[1]);
                check("c10", acc[1][0], e[2]);
                check("c11", acc[1][1], e[3]);
            end
        end
    end

    // pe_load high-cycle counters.
    int loads2 = 0;
    int loads4 = 0;
    always @(negedge clk) begin
        if (pe_load2 === 1'b1) loads2++;
        if (pe_load4 === 1'b1) loads4++;
    end

    // One product on dut2: K beats with nstall idle cycles between beats.
    task automatic run2(input int k, input logic [3:0][2*DW-1:0] av,
                        input logic [3:0][2*DW-1:0] bv, input int nstall,
                        input cmat_t expc);
        int cyc;
        int guard;
        int exp_cyc;
        logic [2*DW-1:0] ha, hb;
        exp_cyc = (k == 0) ? 2 : 1 + k + nstall * (k - 1) + 2 + 1 + 1;
        exp_q.push_back(expc);
        loads2 = 0;
        start2 = 1'b1;
        k_len2 = KW'(k);
        tick();
        cyc    = 1;
        start2 = 1'b0;
        k_len2 = 8'hFF;                         // must be ignored while busy
        check("clear_pulse", pe_clr2, 1'b1);
        for (int b = 0; b < k; b++) begin
            in_valid2 = 1'b1;
            a_vec2    = av[b];
            b_vec2    = bv[b];
            guard     = 0;
            while (in_ready2 !== 1'b1 && guard < 10) begin
                tick();
                cyc++;
                guard++;
            end
            check("in_ready", in_ready2, 1'b1);
            tick();
            cyc++;
            if (nstall > 0 && b < k - 1) begin
                in_valid2 = 1'b0;
                ha = a_edge2;
                hb = b_edge2;
                for (int s = 0; s < nstall; s++) begin
                    check("stall_pe_load", pe_load2, (s == 0));
                    check("stall_a_edge", a_edge2, ha);
                    check("stall_b_edge", b_edge2, hb);
                    tick();
                    cyc++;
                end
            end
        end
        // Garbage beats and a start outside FEED must have no effect.
        in_valid2 = 1'b1;
        a_vec2    = 16'hFFFF;
        b_vec2    = 16'hFFFF;
        start2    = 1'b1;
        guard     = 0;
        while (done2 !== 1'b1 && guard < 50) begin
            tick();
            cyc++;
            guard++;
        end
        start2    = 1'b0;
        in_valid2 = 1'b0;
        check("done_seen", done2, 1'b1);
        check("latency", cyc, exp_cyc);
        check("load_count", loads2, (k == 0) ? 0 : k + 2);
    endtask

    logic [3:0][2*DW-1:0] av1, bv1, av2, bv2, zv;
    cmat_t c1, c6, c0;
    logic [4*DW-1:0] ea, eb;
    int guard4;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; k_len2 = '0; a_vec2 = '0; b_vec2 = '0;
        start4 = 1'b0; in_valid4 = 1'b0; k_len4 = '0; a_vec4 = '0; b_vec4 = '0;

        av1 = '0; bv1 = '0; av2 = '0; bv2 = '0; zv = '0;
        av1[0] = {8'd3, 8'd1}; bv1[0] = {8'd6, 8'd5};
        av1[1] = {8'd4, 8'd2}; bv1[1] = {8'd8, 8'd7};
        av2[0] = {8'd2, 8'd2}; bv2[0] = {8'd3, 8'd3};
        c1[0] = 19; c1[1] = 22; c1[2] = 43; c1[3] = 50;
        c6[0] = 6;  c6[1] = 6;  c6[2] = 6;  c6[3] = 6;
        c0 = '0;

        tick();
        tick();
        check("rst_busy", busy2, 1'b0);
        check("rst_in_ready", in_ready2, 1'b0);
        check("rst_pe_clr", pe_clr2, 1'b0);
        check("rst_pe_load", pe_load2, 1'b0);
        check("rst_done", done2, 1'b0);
        check("rst_a_edge", a_edge2, 16'h0);
        check("rst_b_edge", b_edge2, 16'h0);
        check("rst_a_edge4", a_edge4, 32'h0);
        rst = 1'b0;
        tick();

        // Plain 2x2 product, no stalls.
        run2(2, av1, bv1, 0, c1);
        tick();
        check("idle_after_done", busy2, 1'b0);

        // Same product with 3 stall cycles between beats.
        run2(2, av1, bv1, 3, c1);
        tick();

        // Back-to-back: start in the cycle right after done.
        run2(1, av2, bv2, 0, c6);
        tick();

        // Empty product: clear then done, no loads, results zero.
        run2(0, zv, zv, 0, c0);
        tick();

        // Reset in the middle of FEED abandons the product.
        start2 = 1'b1;
        k_len2 = 8'd2;
        tick();
        start2    = 1'b0;
        in_valid2 = 1'b1;
        a_vec2    = av1[0];
        b_vec2    = bv1[0];
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy2, 1'b0);
        check("mid_rst_in_ready", in_ready2, 1'b0);
        check("mid_rst_pe_load", pe_load2, 1'b0);
        check("mid_rst_pe_clr", pe_clr2, 1'b0);
        check("mid_rst_done", done2, 1'b0);
        check("mid_rst_a_edge", a_edge2, 16'h0);
        check("mid_rst_b_edge", b_edge2, 16'h0);
        rst       = 1'b0;
        in_valid2 = 1'b0;
        tick();
        tick();
        check("post_rst_idle", busy2, 1'b0);
        run2(2, av1, bv1, 0, c1);
        tick();

        // Skew on the 4x4 instance, K = 1.
        loads4 = 0;
        start4 = 1'b1;
        k_len4 = 8'd1;
        tick();
        start4    = 1'b0;
        in_valid4 = 1'b1;
        a_vec4    = {8'd4, 8'd3, 8'd2, 8'd1};
        b_vec4    = {8'd8, 8'd7, 8'd6, 8'd5};
        tick();
        check("skew_in_ready", in_ready4, 1'b1);
        tick();
        in_valid4 = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            ea = '0;
            eb = '0;
            if (n <= 4) begin
                ea[(n-1)*DW +: DW] = DW'(n);
                eb[(n-1)*DW +: DW] = DW'(n + 4);
            end
            check($sformatf("skew_a_edge_adv%0d", n), a_edge4, ea);
            check($sformatf("skew_b_edge_adv%0d", n), b_edge4, eb);
            tick();
        end
        guard4 = 0;
        while (done4 !== 1'b1 && guard4 < 10) begin
            tick();
            guard4++;
        end
        check("skew_done", done4, 1'b1);
        check("skew_load_count", loads4, 7);

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
